// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   funct3_e  - access size/sign encoding of funct3
//   state_e   - LSU FSM states
//   TIMEOUT_CYC_DEF - default bus-ack timeout in cycles
package lsu_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_e;

  localparam int unsigned TIMEOUT_CYC_DEF = 16;

  // True for the funct3 codes valid for the given access direction.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: LSU-to-memory bus.
//   bus_req_o/bus_we_o/bus_addr_o/bus_be_o/bus_wdata_o : LSU -> memory
//   bus_ack_i/bus_rdata_i                              : memory -> LSU
//   modport master = LSU side, modport slave = memory side.
interface lsu_if;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    input  bus_ack_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    output bus_ack_i, bus_rdata_i
  );
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed byte/half lane out of a bus read
// word and sign- or zero-extends it according to funct3.
//   rdata_i  : raw bus read word
//   funct3_i : access size/sign
//   off_i    : byte offset within the word (already aligned for halves)
//   data_o   : formatted load result
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  output logic [31:0] data_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = '0;
    case (off_i)
      2'd0:    lane_b = rdata_i[7:0];
      2'd1:    lane_b = rdata_i[15:8];
      2'd2:    lane_b = rdata_i[23:16];
      default: lane_b = rdata_i[31:24];
    endcase
    lane_h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_B:    data_o = {{24{lane_b[7]}}, lane_b};
      F3_BU:   data_o = {24'h0, lane_b};
      F3_H:    data_o = {{16{lane_h[15]}}, lane_h};
      F3_HU:   data_o = {16'h0, lane_h};
      F3_W:    data_o = rdata_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: MEM-stage load/store unit with a single outstanding bus access.
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   req_valid_i/ready_o    : request handshake (ready only in IDLE)
//   is_store_i, funct3_i, addr_i, st_data_i : request fields
//   ld_data_o, ld_valid_o  : load result (held) and one-cycle valid
//   stall_o                : high while an access is in flight
//   misalign_o, bus_err_o  : one-cycle error pulses
//   bus                    : lsu_if.master memory bus
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses; otherwise they are silently aligned down.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] ld_data_o,
  output logic        ld_valid_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  lsu_if.master       bus
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;
  logic [31:0]   ld_data_q, ld_data_d;
  logic          err_q, err_d;
  logic          mis_q, mis_d;

  logic          illegal;
  logic          trap;
  logic [1:0]    off_aln;
  logic [3:0]    be_new;
  logic [31:0]   wdata_new;
  logic [31:0]   ld_fmt;
  logic          active;

  // Request decode: size comes from funct3[1:0] for every legal code.
  always_comb begin
    illegal   = !f3_legal(is_store_i, funct3_i);
    off_aln   = 2'b00;
    be_new    = 4'b1111;
    wdata_new = st_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        off_aln   = addr_i[1:0];
        be_new    = 4'b0001 << addr_i[1:0];
        wdata_new = {4{st_data_i[7:0]}};
      end
      2'b01: begin
        off_aln   = {addr_i[1], 1'b0};
        be_new    = 4'b0011 << {addr_i[1], 1'b0};
        wdata_new = {2{st_data_i[15:0]}};
      end
      default: begin
        off_aln   = 2'b00;
        be_new    = 4'b1111;
        wdata_new = st_data_i;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    trap = 1'b0;
    if (funct3_i[1:0] == 2'b01) trap = addr_i[0];
    if (funct3_i[1:0] == 2'b10) trap = (addr_i[1:0] != 2'b00);
  end
`else
  assign trap = 1'b0;
`endif

  lsu_load_align u_load_align (
    .rdata_i  (bus.bus_rdata_i),
    .funct3_i (f3_q),
    .off_i    (off_q),
    .data_o   (ld_fmt)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    f3_d      = f3_q;
    off_d     = off_q;
    ld_data_d = ld_data_q;
    err_d     = 1'b0;
    mis_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          we_d    = is_store_i;
          addr_d  = {addr_i[31:2], 2'b00};
          be_d    = be_new;
          wdata_d = wdata_new;
          f3_d    = funct3_i;
          off_d   = off_aln;
          cnt_d   = '0;
          if (illegal)   err_d   = 1'b1;
          else if (trap) mis_d   = 1'b1;
          else           state_d = S_BUS;
        end
      end
      S_BUS: begin
        // Ack is checked before the timeout so a same-cycle ack wins.
        if (bus.bus_ack_i) begin
          state_d = S_RESP;
          if (!we_q) ld_data_d = ld_fmt;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_IDLE;
          err_d     = 1'b1;
          ld_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      ld_data_q <= '0;
      err_q     <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      ld_data_q <= ld_data_d;
      err_q     <= err_d;
      mis_q     <= mis_d;
    end
  end

  assign active          = (state_q != S_IDLE);
  assign req_ready_o     = (state_q == S_IDLE);
  assign stall_o         = active;
  assign ld_valid_o      = (state_q == S_RESP) && !we_q;
  assign ld_data_o       = ld_data_q;
  assign bus_err_o       = err_q;
  assign misalign_o      = mis_q;
  assign bus.bus_req_o   = (state_q == S_BUS);
  assign bus.bus_we_o    = active && we_q;
  assign bus.bus_addr_o  = active ? addr_q  : '0;
  assign bus.bus_be_o    = active ? be_q    : '0;
  assign bus.bus_wdata_o = active ? wdata_q : '0;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;
  import lsu_pkg::*;

  logic        clk;
  logic        rst_ni;
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] st_data;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        stall;
  logic        misalign;
  logic        bus_err;

  int n_tests;
  int n_fail;

  lsu_if bif ();

  lsu #(.TIMEOUT_CYC(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .is_store_i  (is_store),
    .funct3_i    (funct3),
    .addr_i      (addr),
    .st_data_i   (st_data),
    .ld_data_o   (ld_data),
    .ld_valid_o  (ld_valid),
    .stall_o     (stall),
    .misalign_o  (misalign),
    .bus_err_o   (bus_err),
    .bus         (bif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_ld;
  } vec_t;

  vec_t vecs[9];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single cycle; returns in the cycle after acceptance.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d);
    req_valid = 1'b1;
    is_store  = st;
    funct3    = f3;
    addr      = a;
    st_data   = d;
    step();
    req_valid = 1'b0;
  endtask

  int hi;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_ni = 1'b0;
    req_valid = 1'b0;
    is_store = 1'b0;
    funct3 = 3'b000;
    addr = '0;
    st_data = '0;
    bif.bus_ack_i = 1'b0;
    bif.bus_rdata_i = '0;

    //          st  f3      addr          wd            rd            exp_addr      be       exp_wdata     exp_ld
    vecs[0] = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 32'h0000_0100, 4'b1000, 32'h0,        32'hFFFF_FF80};
    vecs[1] = '{1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h80FF_1234, 32'h0000_0100, 4'b1100, 32'h0,        32'h0000_80FF};
    vecs[2] = '{1'b1, 3'b000, 32'h0000_0101, 32'h0000_00AB, 32'h0,        32'h0000_0100, 4'b0010, 32'hABAB_ABAB, 32'h0000_80FF};
    vecs[3] = '{1'b0, 3'b001, 32'h0000_0100, 32'h0,        32'h1234_8001, 32'h0000_0100, 4'b0011, 32'h0,        32'hFFFF_8001};
    vecs[4] = '{1'b0, 3'b100, 32'h0000_0102, 32'h0,        32'h1234_5678, 32'h0000_0100, 4'b0100, 32'h0,        32'h0000_0034};
    vecs[5] = '{1'b0, 3'b010, 32'h0000_0200, 32'h0,        32'hDEAD_BEEF, 32'h0000_0200, 4'b1111, 32'h0,        32'hDEAD_BEEF};
    vecs[6] = '{1'b1, 3'b001, 32'h0000_0102, 32'h1234_5678, 32'h0,        32'h0000_0100, 4'b1100, 32'h5678_5678, 32'hDEAD_BEEF};
    vecs[7] = '{1'b1, 3'b010, 32'h0000_0104, 32'hCAFE_F00D, 32'h0,        32'h0000_0104, 4'b1111, 32'hCAFE_F00D, 32'hDEAD_BEEF};
    vecs[8] = '{1'b0, 3'b000, 32'h0000_0100, 32'h0,        32'h0000_007F, 32'h0000_0100, 4'b0001, 32'h0,        32'h0000_007F};

    step();
    step();
    // Reset state
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_bus_req", bif.bus_req_o, 1'b0);
    chk1("rst_ld_valid", ld_valid, 1'b0);
    chk1("rst_bus_err", bus_err, 1'b0);
    chk1("rst_misalign", misalign, 1'b0);
    chk32("rst_ld_data", ld_data, 32'h0);
    chk32("rst_bus_addr", bif.bus_addr_o, 32'h0);
    chk32("rst_bus_be", {28'h0, bif.bus_be_o}, 32'h0);
    chk32("rst_bus_wdata", bif.bus_wdata_o, 32'h0);
    rst_ni = 1'b1;
    step();

    // Table-driven accesses, ack one cycle after acceptance
    for (int i = 0; i < 9; i++) begin
      do_req(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wd);
      chk1("v_bus_req", bif.bus_req_o, 1'b1);
      chk1("v_stall", stall, 1'b1);
      chk1("v_ready_busy", req_ready, 1'b0);
      chk1("v_bus_we", bif.bus_we_o, vecs[i].st);
      chk32("v_bus_addr", bif.bus_addr_o, vecs[i].exp_addr);
      chk32("v_bus_be", {28'h0, bif.bus_be_o}, {28'h0, vecs[i].exp_be});
      if (vecs[i].st) chk32("v_bus_wdata", bif.bus_wdata_o, vecs[i].exp_wdata);
      bif.bus_ack_i = 1'b1;
      bif.bus_rdata_i = vecs[i].rd;
      step();
      bif.bus_ack_i = 1'b0;
      chk1("v_bus_req_drop", bif.bus_req_o, 1'b0);
      chk1("v_ld_valid", ld_valid, !vecs[i].st);
      chk32("v_ld_data", ld_data, vecs[i].exp_ld);
      step();
      chk1("v_ready_after", req_ready, 1'b1);
      chk1("v_ld_valid_pulse", ld_valid, 1'b0);
      chk32("v_ld_hold", ld_data, vecs[i].exp_ld);
    end

    // Timeout: no ack at all
    do_req(1'b0, 3'b010, 32'h0000_0300, 32'h0);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bif.bus_req_o) break;
      hi++;
      step();
    end
    chk32("to_req_cycles", hi, 32'd16);
    chk1("to_bus_err", bus_err, 1'b1);
    chk1("to_ready", req_ready, 1'b1);
    chk1("to_ld_valid", ld_valid, 1'b0);
    chk32("to_ld_data", ld_data, 32'h0);
    step();
    chk1("to_err_pulse", bus_err, 1'b0);

    // Ack in the 16th BUS cycle wins over the timeout
    do_req(1'b0, 3'b010, 32'h0000_0304, 32'h0);
    repeat (15) step();
    chk1("ack16_bus_req", bif.bus_req_o, 1'b1);
    bif.bus_ack_i = 1'b1;
    bif.bus_rdata_i = 32'h1111_2222;
    step();
    bif.bus_ack_i = 1'b0;
    chk1("ack16_ld_valid", ld_valid, 1'b1);
    chk32("ack16_ld_data", ld_data, 32'h1111_2222);
    chk1("ack16_no_err", bus_err, 1'b0);
    step();
    chk1("ack16_no_err_after", bus_err, 1'b0);

    // Illegal funct3 on a load, and an unsigned code on a store
    do_req(1'b0, 3'b011, 32'h0000_0400, 32'h0);
    chk1("ill_ld_bus_req", bif.bus_req_o, 1'b0);
    chk1("ill_ld_err", bus_err, 1'b1);
    chk1("ill_ld_ready", req_ready, 1'b1);
    step();
    chk1("ill_ld_err_pulse", bus_err, 1'b0);
    do_req(1'b1, 3'b100, 32'h0000_0400, 32'h5);
    chk1("ill_st_bus_req", bif.bus_req_o, 1'b0);
    chk1("ill_st_err", bus_err, 1'b1);
    step();
    chk1("ill_st_err_pulse", bus_err, 1'b0);
    chk32("ill_ld_hold", ld_data, 32'h1111_2222);

    // Misaligned word
`ifdef LSU_MISALIGN_TRAP_EN
    do_req(1'b0, 3'b010, 32'h0000_0102, 32'h0);
    chk1("mis_pulse", misalign, 1'b1);
    chk1("mis_no_bus_req", bif.bus_req_o, 1'b0);
    chk1("mis_no_err", bus_err, 1'b0);
    step();
    chk1("mis_pulse_end", misalign, 1'b0);
    chk1("mis_ready", req_ready, 1'b1);
`else
    do_req(1'b0, 3'b010, 32'h0000_0102, 32'h0);
    chk1("mis_tied", misalign, 1'b0);
    chk32("mis_bus_addr", bif.bus_addr_o, 32'h0000_0100);
    chk32("mis_bus_be", {28'h0, bif.bus_be_o}, 32'hF);
    bif.bus_ack_i = 1'b1;
    bif.bus_rdata_i = 32'hA5A5_5A5A;
    step();
    bif.bus_ack_i = 1'b0;
    chk32("mis_ld_data", ld_data, 32'hA5A5_5A5A);
    step();
    do_req(1'b0, 3'b001, 32'h0000_0103, 32'h0);
    chk32("mis_h_be", {28'h0, bif.bus_be_o}, 32'hC);
    bif.bus_ack_i = 1'b1;
    bif.bus_rdata_i = 32'h8765_4321;
    step();
    bif.bus_ack_i = 1'b0;
    chk32("mis_h_ld_data", ld_data, 32'hFFFF_8765);
    step();
`endif

    // Reset in the middle of a bus access; the later ack must be ignored
    do_req(1'b0, 3'b010, 32'h0000_0500, 32'h0);
    chk1("rb_bus_req", bif.bus_req_o, 1'b1);
    rst_ni = 1'b0;
    step();
    chk1("rb_bus_req_off", bif.bus_req_o, 1'b0);
    chk1("rb_ready", req_ready, 1'b1);
    chk1("rb_stall", stall, 1'b0);
    chk32("rb_ld_data", ld_data, 32'h0);
    chk32("rb_bus_addr", bif.bus_addr_o, 32'h0);
    rst_ni = 1'b1;
    bif.bus_ack_i = 1'b1;
    bif.bus_rdata_i = 32'h7777_7777;
    step();
    bif.bus_ack_i = 1'b0;
    chk1("rb_late_ack_req", bif.bus_req_o, 1'b0);
    chk1("rb_late_ack_valid", ld_valid, 1'b0);
    chk1("rb_late_ack_ready", req_ready, 1'b1);
    step();
    chk1("rb_late_ack_valid2", ld_valid, 1'b0);
    chk32("rb_late_ack_data", ld_data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
